// File: rtl/serial_addsub_seq_pkg.sv
// serial_addsub_seq_pkg: shared opcodes, FSM states and slice width for the serial add/sub engine
package serial_addsub_seq_pkg;
  localparam logic [1:0] OP_ADD = 2'b01;
  localparam logic [1:0] OP_SUB = 2'b10;
  localparam int NIBBLE_W = 4;
  typedef enum logic [1:0] {IDLE, RUN, DONE} stateT;
endpackage

// File: rtl/serial_addsub_seq_if.sv
// serial_addsub_seq_if: request/result bundle between issuer and the serial add/sub engine
interface serial_addsub_seq_if import serial_addsub_seq_pkg::*; #(parameter int NIBBLES = 4);
  localparam int W = NIBBLE_W * NIBBLES;
  logic start;
  logic [1:0] opCode;
  logic [W-1:0] A;
  logic [W-1:0] B;
  logic busy;
  logic done;
  logic [W-1:0] Y;
  logic CarryOUT;
  logic overflow;
  logic opError;
  modport master(output start, opCode, A, B, input busy, done, Y, CarryOUT, overflow, opError);
  modport slave(input start, opCode, A, B, output busy, done, Y, CarryOUT, overflow, opError);
endinterface

// File: rtl/serial_addsub_seq_nibble_adder.sv
// nibble_adder: combinational 4-bit adder with carry in/out
module nibble_adder import serial_addsub_seq_pkg::*; (
  input  logic [NIBBLE_W-1:0] a,
  input  logic [NIBBLE_W-1:0] b,
  input  logic                cin,
  output logic [NIBBLE_W-1:0] sum,
  output logic                cout
);
  assign {cout, sum} = {1'b0, a} + {1'b0, b} + {{NIBBLE_W{1'b0}}, cin};
endmodule

// File: rtl/serial_addsub_seq.sv
// serial_addsub_seq: wide add/subtract computed one nibble per clock, LSB first
module serial_addsub_seq import serial_addsub_seq_pkg::*; #(parameter int NIBBLES = 4) (
  input logic clk,
  input logic rst,
  serial_addsub_seq_if.slave bus
);
  localparam int W = NIBBLE_W * NIBBLES;
  localparam int CW = NIBBLES > 1 ? $clog2(NIBBLES) : 1;
  stateT state, stateNext;
  logic [CW-1:0] cnt;
  logic [W-1:0] aReg, bReg, part, partNext, yReg;
  logic c, carryReg, ovReg, errReg;
  logic [NIBBLE_W-1:0] sum;
  logic cout, valid, idle, accept, reject, last;
  nibble_adder u_add (.a(aReg[NIBBLE_W-1:0]), .b(bReg[NIBBLE_W-1:0]), .cin(c), .sum(sum), .cout(cout));
  always_ff @(posedge clk)
    if (rst) state <= IDLE;
    else state <= stateNext;
  always_comb begin
    valid = bus.opCode == OP_ADD || bus.opCode == OP_SUB;
    idle = state != RUN;
    accept = bus.start && valid && idle;
    reject = bus.start && !valid && idle;
    last = cnt == CW'(NIBBLES - 1);
    stateNext = state == RUN ? (last ? DONE : RUN) : accept ? RUN : reject ? DONE : IDLE;
    partNext = (part >> NIBBLE_W) | (W'(sum) << (W - NIBBLE_W));
  end
  // bReg holds B already inverted for subtract, so the top-nibble sign test is the same for both ops
  always_ff @(posedge clk)
    if (rst) begin
      cnt <= '0;
      aReg <= '0;
      bReg <= '0;
      part <= '0;
      c <= 1'b0;
      yReg <= '0;
      carryReg <= 1'b0;
      ovReg <= 1'b0;
      errReg <= 1'b0;
    end else begin
      errReg <= reject;
      if (accept) begin
        cnt <= '0;
        aReg <= bus.A;
        bReg <= bus.opCode == OP_SUB ? ~bus.B : bus.B;
        c <= bus.opCode == OP_SUB;
      end else if (state == RUN) begin
        cnt <= cnt + 1'b1;
        aReg <= aReg >> NIBBLE_W;
        bReg <= bReg >> NIBBLE_W;
        part <= partNext;
        c <= cout;
        if (last) begin
          yReg <= partNext;
          carryReg <= cout;
          ovReg <= aReg[NIBBLE_W-1] == bReg[NIBBLE_W-1] && sum[NIBBLE_W-1] != aReg[NIBBLE_W-1];
        end
      end
    end
  assign bus.busy = state == RUN;
  assign bus.done = state == DONE;
  assign bus.opError = errReg;
  assign bus.Y = yReg;
  assign bus.CarryOUT = carryReg;
  assign bus.overflow = ovReg;
endmodule
